// File: rtl/write_buffer_pkg.sv
// Shared definitions for the AHB-side write buffer: default sizes, parity mode
// and the parity helper used on the consumer-facing data word.
package write_buffer_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_DEPTH = 4;
   localparam int MAX_WIDTH     = 64;

   typedef enum logic {
      PARITY_EVEN = 1'b0,
      PARITY_ODD  = 1'b1
   } parity_mode_e;

   // Callers zero-extend narrower words to MAX_WIDTH; padding zeros leave the
   // XOR reduction unchanged.
   function automatic logic calc_parity(input logic [MAX_WIDTH-1:0] data,
                                        input parity_mode_e         mode);
      return (^data) ^ (mode == PARITY_ODD);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO with occupancy counter; full/empty come from the count so the
// pointers can wrap freely with no spare slot.
module wb_fifo
   import write_buffer_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_wrEn,
   input  logic [WIDTH-1:0] i_wrData,
   input  logic             i_rdEn,
   output logic [WIDTH-1:0] o_rdData,
   output logic             o_full,
   output logic             o_empty
);

   localparam int            AW         = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);
   localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full   = (r_count == FULL_COUNT);
   assign o_empty  = (r_count == '0);
   assign w_push   = i_wrEn && !o_full;
   assign w_pop    = i_rdEn && !o_empty;
   assign o_rdData = r_mem[r_rdPtr];

   // Storage is intentionally left out of reset; only the bookkeeping is cleared.
   always_ff @(posedge i_clk) begin
      if (w_push && !i_rst) begin
         r_mem[r_wrPtr] <= i_wrData;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_ONE;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_ONE;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/write_buffer_ahb.sv
// Write buffer between an AHB-style producer and a request/acknowledge consumer,
// with zero-masked output data and selectable even/odd parity.
module write_buffer_ahb
   import write_buffer_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] HRDATA,
   input  logic             HREADYOUT,
   output logic             HREADY,
   output logic             YREQ,
   input  logic             YACK,
   output logic [WIDTH-1:0] YDATA,
   input  logic             PARITYSEL,
   output logic             YPARITY
);

   logic [WIDTH-1:0]     w_rdData;
   logic                 w_full;
   logic                 w_empty;
   logic [MAX_WIDTH-1:0] w_parityIn;
   parity_mode_e         w_mode;

   wb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_wrEn   (HREADYOUT),
      .i_wrData (HRDATA),
      .i_rdEn   (YACK),
      .o_rdData (w_rdData),
      .o_full   (w_full),
      .o_empty  (w_empty)
   );

   assign HREADY = !w_full;
   assign YREQ   = !w_empty;
   assign YDATA  = w_empty ? '0 : w_rdData;

   always_comb begin
      w_parityIn            = '0;
      w_parityIn[WIDTH-1:0] = YDATA;
   end

   assign w_mode  = PARITYSEL ? PARITY_ODD : PARITY_EVEN;
   assign YPARITY = calc_parity(w_parityIn, w_mode);

endmodule

// File: tb/tb_write_buffer_ahb.sv
// Scoreboard bench for write_buffer_ahb: directed scenarios plus random traffic
// compared against a queue-based reference of the buffer contents.
module tb_write_buffer_ahb;

   localparam int DEPTH = 4;
   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] HRDATA;
   logic             HREADYOUT;
   logic             HREADY;
   logic             YREQ;
   logic             YACK;
   logic [WIDTH-1:0] YDATA;
   logic             PARITYSEL;
   logic             YPARITY;

   int               checksTotal  = 0;
   int               checksPassed = 0;
   bit               monitorOn    = 1'b0;
   logic [WIDTH-1:0] expQ [$];
   logic [WIDTH-1:0] monData;
   logic             monPar;
   bit               doPush;
   bit               doPop;

   write_buffer_ahb #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .HRDATA    (HRDATA),
      .HREADYOUT (HREADYOUT),
      .HREADY    (HREADY),
      .YREQ      (YREQ),
      .YACK      (YACK),
      .YDATA     (YDATA),
      .PARITYSEL (PARITYSEL),
      .YPARITY   (YPARITY)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                              input logic [WIDTH-1:0] expected);
      checksTotal++;
      if (actual === expected) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs, let the edge consume them, return just after it.
   task automatic applyStimulus(input logic push, input logic [WIDTH-1:0] data,
                                input logic ack);
      HREADYOUT = push;
      HRDATA    = data;
      YACK      = ack;
      @(posedge clk);
      #1;
   endtask

   function automatic logic expectedParity(input logic [WIDTH-1:0] word, input logic sel);
      return (($countones(word) % 2) == 1) ^ sel;
   endfunction

   // Reference model: buffer is just an ordered list of accepted words.
   always @(posedge clk) begin
      if (rst) begin
         expQ.delete();
      end else begin
         doPop  = (expQ.size() != 0) && YACK;
         doPush = HREADYOUT && (expQ.size() != DEPTH);
         if (doPop) begin
            void'(expQ.pop_front());
         end
         if (doPush) begin
            expQ.push_back(HRDATA);
         end
      end
   end

   // Monitor: every cycle the visible outputs must match the model's head word.
   always @(negedge clk) begin
      if (monitorOn) begin
         monData = (expQ.size() != 0) ? expQ[0] : '0;
         monPar  = expectedParity(monData, PARITYSEL);
         checkOutput("mon_HREADY", {31'b0, HREADY}, {31'b0, expQ.size() != DEPTH});
         checkOutput("mon_YREQ", {31'b0, YREQ}, {31'b0, expQ.size() != 0});
         checkOutput("mon_YDATA", YDATA, monData);
         checkOutput("mon_YPARITY", {31'b0, YPARITY}, {31'b0, monPar});
      end
   end

   logic [WIDTH-1:0] sweepWords [3];
   logic             sweepEven  [3];
   logic             sweepOdd   [3];

   initial begin
      sweepWords = '{32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001};
      sweepEven  = '{1'b0, 1'b0, 1'b1};
      sweepOdd   = '{1'b1, 1'b1, 1'b0};

      rst       = 1'b1;
      PARITYSEL = 1'b1;
      HREADYOUT = 1'b0;
      HRDATA    = '0;
      YACK      = 1'b0;
      applyStimulus(1'b0, '0, 1'b0);
      monitorOn = 1'b1;
      applyStimulus(1'b0, '0, 1'b0);
      rst = 1'b0;
      #1;
      checkOutput("reset_HREADY", {31'b0, HREADY}, 32'd1);
      checkOutput("reset_YREQ", {31'b0, YREQ}, 32'd0);
      checkOutput("reset_YDATA", YDATA, 32'd0);
      checkOutput("reset_YPARITY", {31'b0, YPARITY}, 32'd1);

      $display("[TB] single word");
      PARITYSEL = 1'b0;
      applyStimulus(1'b1, 32'h0000_0003, 1'b0);
      checkOutput("single_YREQ", {31'b0, YREQ}, 32'd1);
      checkOutput("single_YDATA", YDATA, 32'h3);
      checkOutput("single_par_even", {31'b0, YPARITY}, 32'd0);
      PARITYSEL = 1'b1;
      #1;
      checkOutput("single_par_odd", {31'b0, YPARITY}, 32'd1);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("single_pop_YREQ", {31'b0, YREQ}, 32'd0);

      $display("[TB] fill and drain");
      PARITYSEL = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'hA0 + i, 1'b0);
      end
      checkOutput("fill_HREADY", {31'b0, HREADY}, 32'd0);
      applyStimulus(1'b1, 32'hFF, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checkOutput("drain_YDATA", YDATA, 32'hA0 + i);
         applyStimulus(1'b0, '0, 1'b1);
         checkOutput("drain_HREADY", {31'b0, HREADY}, 32'd1);
      end
      checkOutput("drain_YREQ", {31'b0, YREQ}, 32'd0);

      $display("[TB] simultaneous push and pop");
      applyStimulus(1'b1, 32'hB0, 1'b0);
      applyStimulus(1'b1, 32'hB1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         checkOutput("simul_YDATA", YDATA, 32'hB0 + i);
         applyStimulus(1'b1, 32'hB2 + i, 1'b1);
         checkOutput("simul_HREADY", {31'b0, HREADY}, 32'd1);
         checkOutput("simul_YREQ", {31'b0, YREQ}, 32'd1);
      end
      checkOutput("simul_tail0", YDATA, 32'hBA);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("simul_tail1", YDATA, 32'hBB);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("simul_empty", {31'b0, YREQ}, 32'd0);

      $display("[TB] push and ack on empty buffer");
      applyStimulus(1'b1, 32'h55, 1'b1);
      checkOutput("empty_ack_YREQ", {31'b0, YREQ}, 32'd1);
      checkOutput("empty_ack_YDATA", YDATA, 32'h55);
      applyStimulus(1'b0, '0, 1'b1);

      $display("[TB] parity sweep");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, sweepWords[i], 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         PARITYSEL = 1'b0;
         #1;
         checkOutput("sweep_even", {31'b0, YPARITY}, {31'b0, sweepEven[i]});
         PARITYSEL = 1'b1;
         #1;
         checkOutput("sweep_odd", {31'b0, YPARITY}, {31'b0, sweepOdd[i]});
         applyStimulus(1'b0, '0, 1'b1);
      end

      $display("[TB] mid-stream reset");
      PARITYSEL = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'hC0 + i, 1'b0);
      end
      PARITYSEL = 1'b1;
      rst       = 1'b1;
      applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1);
      rst = 1'b0;
      checkOutput("midrst_HREADY", {31'b0, HREADY}, 32'd1);
      checkOutput("midrst_YREQ", {31'b0, YREQ}, 32'd0);
      checkOutput("midrst_YDATA", YDATA, 32'd0);
      checkOutput("midrst_YPARITY", {31'b0, YPARITY}, 32'd1);
      applyStimulus(1'b0, '0, 1'b0);

      $display("[TB] random traffic");
      for (int i = 0; i < 500; i++) begin
         PARITYSEL = 1'($urandom_range(0, 1));
         rst       = ($urandom_range(0, 99) == 0);
         applyStimulus($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 5);
      end
      rst = 1'b0;
      applyStimulus(1'b0, '0, 1'b0);

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
